// File: rtl/range_pkg.sv
// rtl/range_pkg.sv - shared scan states, BCD digit type and RAM geometry
package range_pkg;

  localparam int RAM_WORDS_DEF     = 16;
  localparam int RAM_ADDR_BITS_DEF = 4;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_CAPT,
    S_CONV,
    S_EMIT,
    S_DONE
  } scan_state_e;

  // One shift-add-3 step over {bcd[19:0], bin[15:0]}.
  function automatic logic [35:0] bcd_step(input logic [35:0] v);
    logic [35:0] t;
    bcd_digit_t  d;
    t = v;
    for (int i = 0; i < 5; i++) begin
      d = t[16+4*i +: 4];
      if (d >= 4'd5) t[16+4*i +: 4] = d + 4'd3;
    end
    return {t[34:0], 1'b0};
  endfunction

endpackage

// File: rtl/bin2bcd16.sv
// rtl/bin2bcd16.sv - iterative 16-bit binary to five-digit BCD converter
module bin2bcd16
  import range_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        done,
  output logic [19:0] bcd
);

  logic [35:0] sh_q, sh_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        run_q, run_d;

  // done marks the cycle whose closing edge performs the final iteration.
  assign done = run_q && (cnt_q == 4'd15);
  assign bcd  = sh_q[35:16];

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      sh_d  = {20'd0, bin};
      cnt_d = 4'd0;
      run_d = 1'b1;
    end else if (run_q) begin
      sh_d  = bcd_step(sh_q);
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/range_scan.sv
// rtl/range_scan.sv - walks the count RAM, emits each count as BCD and tracks the maximum
module range_scan
  import range_pkg::*;
#(
  parameter int RAM_WORDS     = RAM_WORDS_DEF,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     go,
  input  logic                     rdone,
  output logic [RAM_ADDR_BITS-1:0] raddr,
  input  logic [15:0]              rcount,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RAM_ADDR_BITS-1:0] out_idx,
  output logic [19:0]              out_bcd,
  output logic [15:0]              max_count,
  output logic [RAM_ADDR_BITS-1:0] max_idx,
  output logic                     busy,
  output logic                     scan_done,
  output logic                     abort
);

  scan_state_e              state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] raddr_q, raddr_d;
  logic [15:0]              max_count_q, max_count_d;
  logic [RAM_ADDR_BITS-1:0] max_idx_q, max_idx_d;
  logic                     scan_done_q, scan_done_d;
  logic                     abort_q, abort_d;
  logic                     busy_s;
  logic                     conv_start;
  logic                     conv_done;
  logic [19:0]              conv_bcd;

  bin2bcd16 u_bin2bcd16 (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (conv_start),
    .bin     (rcount),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  assign busy_s    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign busy      = busy_s;
  assign raddr     = raddr_q;
  assign out_valid = (state_q == S_EMIT);
  assign out_idx   = raddr_q;
  assign out_bcd   = conv_bcd;
  assign max_count = max_count_q;
  assign max_idx   = max_idx_q;
  assign scan_done = scan_done_q;
  assign abort     = abort_q;

  always_comb begin
    state_d     = state_q;
    raddr_d     = raddr_q;
    max_count_d = max_count_q;
    max_idx_d   = max_idx_q;
    scan_done_d = scan_done_q;
    abort_d     = 1'b0;
    conv_start  = 1'b0;
    if (busy_s && !rdone) begin
      state_d = S_IDLE;
      abort_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (go && rdone) begin
            state_d     = S_ADDR;
            raddr_d     = '0;
            max_count_d = '0;
            max_idx_d   = '0;
            scan_done_d = 1'b0;
          end
        end
        S_ADDR: state_d = S_WAIT;
        S_WAIT: state_d = S_CAPT;
        S_CAPT: begin
          // Strict compare so an equal later count keeps the earlier index.
          conv_start = 1'b1;
          if (rcount > max_count_q) begin
            max_count_d = rcount;
            max_idx_d   = raddr_q;
          end
          state_d = S_CONV;
        end
        S_CONV: if (conv_done) state_d = S_EMIT;
        S_EMIT: begin
          if (out_ready) begin
            if (raddr_q == RAM_ADDR_BITS'(RAM_WORDS - 1)) begin
              state_d     = S_DONE;
              scan_done_d = 1'b1;
            end else begin
              state_d = S_ADDR;
              raddr_d = raddr_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      raddr_q     <= '0;
      max_count_q <= '0;
      max_idx_q   <= '0;
      scan_done_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      max_count_q <= max_count_d;
      max_idx_q   <= max_idx_d;
      scan_done_q <= scan_done_d;
      abort_q     <= abort_d;
    end
  end

endmodule
